// File: rtl/fc_layer_bridge.sv
// rtl/fc_layer_bridge.sv - vector-capture stream bridge between fc layers; FC_BRIDGE_PINGPONG_EN selects two banks
module fc_layer_bridge #(
    parameter int M = 8,
    parameter int T = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [T-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [T-1:0] out_data,
    output logic         out_last,
    output logic         vec_done
);
    localparam int AW = $clog2(M);
    localparam logic [AW-1:0] LAST = AW'(M - 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          in_hs;
    logic          out_hs;
    logic          fill_done;
    logic          drain_done;

    assign in_hs      = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign fill_done  = in_hs && (wr_ptr == LAST);
    assign drain_done = out_hs && (rd_ptr == LAST);
    assign out_last   = out_valid && (rd_ptr == LAST);

`ifdef FC_BRIDGE_PINGPONG_EN
    logic [T-1:0] mem [2][M];
    logic         fill_sel;
    logic         drain_sel;
    logic [1:0]   full;

    // in_ready is gated by reset so it reads low while reset is held
    assign in_ready  = reset && !full[fill_sel];
    assign out_valid = full[drain_sel];
    assign out_data  = out_valid ? mem[drain_sel][rd_ptr] : '0;

    // fill and drain always target different banks, so both completions may land together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            full      <= 2'b00;
        end else begin
            if (fill_done)
                fill_sel <= ~fill_sel;
            if (drain_done)
                drain_sel <= ~drain_sel;
            if (fill_done && !fill_sel)
                full[0] <= 1'b1;
            else if (drain_done && !drain_sel)
                full[0] <= 1'b0;
            if (fill_done && fill_sel)
                full[1] <= 1'b1;
            else if (drain_done && drain_sel)
                full[1] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs)
            mem[fill_sel][wr_ptr] <= in_data;
    end
`else
    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [T-1:0] mem [M];
    logic [0:0]   state;

    assign in_ready  = reset && (state == FILL);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FILL;
        else if (fill_done)
            state <= DRAIN;
        else if (drain_done)
            state <= FILL;
    end

    always_ff @(posedge clk) begin
        if (in_hs)
            mem[wr_ptr] <= in_data;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            vec_done <= 1'b0;
        end else begin
            if (in_hs)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (out_hs)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            vec_done <= drain_done;
        end
    end
endmodule

// File: doc/fc_layer_bridge.md
# fc_layer_bridge

Stream buffer that sits on the output side of an fc layer and acts as the receiver for its `output_valid`/`output_ready`/`output_data` stream. It captures one complete M-word result vector, then retransmits the vector in order on a second valid/ready stream sized to feed the next fc layer's `input_valid`/`input_ready`/`input_data` port. It decouples the two layers' handshakes and marks the last word of each vector.

## Interface
- `M`, 8: words per vector, equal to the upstream layer's M and the downstream layer's N; M ≥ 2.
- `T`, 16: word width in bits, signed.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: one clock; reset is asynchronous and active-low.
- `in_valid` input, 1 bit: upstream word valid; connects to the layer's `output_valid`.
- `in_ready` output, 1 bit: bridge accepts a word this cycle; connects to the layer's `output_ready`.
- `in_data` input, T bits: upstream word.
- `out_valid` output, 1 bit: downstream word valid.
- `out_ready` input, 1 bit: downstream accepts.
- `out_data` output, T bits: downstream word.
- `out_last` output, 1 bit: high with `out_valid` on word index M-1.
- `vec_done` output, 1 bit: one-cycle pulse after the final downstream handshake of a vector.

## Operation
- Storage: M×T register array per bank. Write pointer and read pointer are each `$clog2(M)` bits wide.
- Handshakes:
  - An input handshake occurs when `in_valid && in_ready`.
  - An output handshake occurs when `out_valid && out_ready`.
  - The bridge passes data unmodified; there is no arithmetic and no width change.
- FSM states (single-bank build):
  - **FILL**: `in_ready`=1 and `out_valid`=0. Each input handshake writes `in_data` to `mem[wr_ptr]` and increments `wr_ptr`. On the handshake with `wr_ptr`=M-1, `wr_ptr` wraps to 0 and the FSM goes to DRAIN.
  - **DRAIN**: `in_ready`=0 and `out_valid`=1. `out_data`=`mem[rd_ptr]`. Each output handshake increments `rd_ptr`. On the handshake with `rd_ptr`=M-1, `rd_ptr` wraps to 0 and the FSM goes to FILL.
- `out_last` = DRAIN && `rd_ptr`==M-1.
- `vec_done` is registered. It is high in the cycle after the final output handshake of a vector.
- Stall rules:
  - While `out_ready`=0, `out_data`, `out_last` and `rd_ptr` hold.
  - While `in_valid`=0, `wr_ptr` holds.
  - `out_valid` never drops once raised until its handshake completes.
- Reset:
  - Asserting `reset` (low) at any time forces FILL and clears both pointers and the bank-state flags.
  - `in_ready`, `out_valid`, `out_last` and `vec_done` go low while reset is asserted. `out_data` is 0.
  - Array contents are not cleared; stale data is never presented.
  - A partially received or partially sent vector is discarded.
- Reset values after release: `in_ready`=1 (FILL), `out_valid`=0, `out_last`=0, `vec_done`=0, `out_data`=0.

## Timing
- Latency: the first word is valid on `out_data` in the cycle after the M-th input handshake.
- Throughput, single bank: M input cycles plus M output cycles per vector at full rate. There is no idle cycle between DRAIN→FILL or FILL→DRAIN.
- `in_ready`, `out_valid`, `out_last` and `out_data` depend only on registered state. There is no combinational path from `in_valid` or `out_ready`.

## Configuration
- `FC_BRIDGE_PINGPONG_EN` defined:
  - Two banks, A and B, each with a full flag. Filling and draining proceed concurrently on opposite banks.
  - `in_ready` = the fill bank is not full. `out_valid` = the drain bank is full.
  - Completing a fill sets that bank's full flag and toggles the fill-bank select. Completing a drain clears that bank's full flag and toggles the drain-bank select.
  - A fill completion and a drain completion in the same cycle both take effect.
  - A newly full bank is presented in the next cycle with no bubble.
  - Sustained throughput is 1 word/cycle.
  - Output order is strictly vector order.
- `FC_BRIDGE_PINGPONG_EN` undefined: single bank with the FILL/DRAIN FSM described above.

## Test plan
- Reset, then feed 8 words 1..8 back-to-back with `out_ready`=1 → `out_data` is 1..8 on cycles 9..16. `out_last` is high only on word 8. `vec_done` pulses on cycle 17.
- Same vector with `out_ready` toggling 1,0,1,0 → every word appears exactly once, in order. Data is held stable during stalls.
- `in_valid` gaps (words -32768, 32767, -1, 0, 5, 6, 7, 8 with idle cycles between) → the values are reproduced bit-exact with sign preserved.
- Drive `reset` low after 5 words received → `in_ready`=0 and `out_valid`=0 during reset. After release, a fresh vector 11..18 outputs exactly 11..18.
- Single bank: hold `in_valid`=1 during DRAIN → `in_ready`=0 and no word is lost. The next vector starts from `wr_ptr`=0.
- With `FC_BRIDGE_PINGPONG_EN`: stream 3 vectors continuously with `out_ready`=1 → 24 outputs on consecutive cycles starting at cycle 9. `in_ready` never drops. A fill/drain completion collision on the same cycle is handled correctly.
